hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It consumes decoded control and register specifiers from ID/EX/MEM/WB and produces forwarding selects, stall/flush enables, and issue control for a fixed-latency multiply/divide unit. Forwarding is combinational. The multiply/divide sequencer and the stall performance counter are registered. It sits beside the datapath, fed by the main decoder's pipelined outputs.

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decoded pipeline specifiers in, forwarding/stall/mult-div control out.
// master = pipeline/decoder side, slave = hazard controller.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       rs_d, rt_d;
  logic             branch_d, pcsrc_d, jump_d, md_req_d, md_read_d;
  logic [4:0]       rs_e, rt_e, writereg_e;
  logic             regwrite_e;
  logic [1:0]       memtoreg_e;
  logic [4:0]       writereg_m;
  logic             regwrite_m;
  logic [1:0]       memtoreg_m;
  logic [4:0]       writereg_w;
  logic             regwrite_w;
  logic [1:0]       forward_a_e, forward_b_e;
  logic             forward_a_d, forward_b_d;
  logic             stall_f, stall_d, flush_d, flush_e;
  logic             md_start, md_busy, md_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs_d, rt_d, branch_d, pcsrc_d, jump_d, md_req_d, md_read_d,
           rs_e, rt_e, writereg_e, regwrite_e, memtoreg_e,
           writereg_m, regwrite_m, memtoreg_m, writereg_w, regwrite_w,
    input  forward_a_e, forward_b_e, forward_a_d, forward_b_d,
           stall_f, stall_d, flush_d, flush_e, md_start, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  rs_d, rt_d, branch_d, pcsrc_d, jump_d, md_req_d, md_read_d,
           rs_e, rt_e, writereg_e, regwrite_e, memtoreg_e,
           writereg_m, regwrite_m, memtoreg_m, writereg_w, regwrite_w,
    output forward_a_e, forward_b_e, forward_a_d, forward_b_d,
           stall_f, stall_d, flush_d, flush_e, md_start, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard controller: combinational forwarding/stall/flush, registered mult/div
// sequencer (IDLE/BUSY with down-counter) and saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic         clk_i,
  input logic         reset_ni,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  md_state_e        state_q;
  logic [3:0]       cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic lwstall, brstall, mdstall, stall, md_start, md_busy;
  logic ex_hit_d, mem_hit_d;

  // Register 0 is hardwired, so a zero specifier never participates in a match.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (hz.regwrite_m && hit(src, hz.writereg_m))
      return 2'b10;
    else if (hz.regwrite_w && hit(src, hz.writereg_w))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign hz.forward_a_e = fwd_sel(hz.rs_e);
  assign hz.forward_b_e = fwd_sel(hz.rt_e);
  assign hz.forward_a_d = hz.regwrite_m && hit(hz.rs_d, hz.writereg_m);
  assign hz.forward_b_d = hz.regwrite_m && hit(hz.rt_d, hz.writereg_m);

  assign ex_hit_d  = hit(hz.rs_d, hz.writereg_e) || hit(hz.rt_d, hz.writereg_e);
  assign mem_hit_d = hit(hz.rs_d, hz.writereg_m) || hit(hz.rt_d, hz.writereg_m);

  assign lwstall = (hz.memtoreg_e == 2'b01) && hz.regwrite_e && ex_hit_d;
  assign brstall = hz.branch_d &&
                   ((hz.regwrite_e && ex_hit_d) ||
                    ((hz.memtoreg_m == 2'b01) && hz.regwrite_m && mem_hit_d));
  assign md_busy = (state_q == BUSY);
  assign mdstall = md_busy && (hz.md_req_d || hz.md_read_d);
  assign stall   = lwstall || brstall || mdstall;

  assign hz.stall_f = stall;
  assign hz.stall_d = stall;
  assign hz.flush_e = stall;
  // A stalled branch/jump is re-evaluated next cycle, so it must not flush yet.
  assign hz.flush_d = (hz.pcsrc_d || hz.jump_d) && !stall;

  assign md_start     = (state_q == IDLE) && hz.md_req_d && !stall;
  assign hz.md_start  = md_start;
  assign hz.md_busy   = md_busy;
  assign hz.md_done   = md_busy && (cnt_q == 4'd1);
  assign hz.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: if (md_start) begin
          state_q <= BUSY;
          cnt_q   <= 4'(MD_LAT - 1);
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      stall_cnt_q <= '0;
    else if (stall && !(&stall_cnt_q))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

endmodule
